// File: rtl/pc_gen_pkg.sv
// pc_gen shared definitions: branch op codes, reset/exception defaults, FSM states.
// Used by pc_gen and pc_target_calc (PC_ALIGN_CHECK_EN selects the alignment trap in pc_gen).
package pc_gen_pkg;

   localparam logic [3:0] BR_OP_NONE = 4'd0;
   localparam logic [3:0] BR_OP_BEQ  = 4'd1;
   localparam logic [3:0] BR_OP_J    = 4'd2;
   localparam logic [3:0] BR_OP_JR   = 4'd3;
   localparam logic [3:0] BR_OP_BNE  = 4'd4;
   localparam logic [3:0] BR_OP_BGEZ = 4'd5;
   localparam logic [3:0] BR_OP_BGTZ = 4'd6;
   localparam logic [3:0] BR_OP_BLEZ = 4'd7;
   localparam logic [3:0] BR_OP_BLTZ = 4'd8;

   localparam logic [31:0] DEF_RESET_PC   = 32'hBFC0_0000;
   localparam logic [31:0] DEF_EXC_VECTOR = 32'hBFC0_0380;

   localparam logic [0:0] ST_SEQ     = 1'b0;
   localparam logic [0:0] ST_WAIT_DS = 1'b1;

endpackage

// File: rtl/pc_target_calc.sv
// Branch/jump resolution: taken flag and target address from the ID-stage operands.
// Purely combinational; rs/rt compare is done here so no external equal flag is needed.
module pc_target_calc
   import pc_gen_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [3:0]        br_op_i,
   input  logic [ADDR_W-1:0] br_pc_i,
   input  logic [25:0]       imm26_i,
   input  logic [ADDR_W-1:0] rs_i,
   input  logic [ADDR_W-1:0] rt_i,
   output logic              taken_o,
   output logic [ADDR_W-1:0] target_o
);

   logic [ADDR_W-1:0] pc4;
   logic [ADDR_W-1:0] b16;
   logic [ADDR_W-1:0] j26;
   logic              rs_neg;
   logic              rs_zero;
   logic              eq;

   assign pc4     = br_pc_i + ADDR_W'(4);
   assign b16     = pc4 + {{(ADDR_W-18){imm26_i[15]}}, imm26_i[15:0], 2'b00};
   assign rs_neg  = rs_i[ADDR_W-1];
   assign rs_zero = (rs_i == '0);
   assign eq      = (rs_i == rt_i);

   // jump region keeps the upper bits of the delay-slot address
   always_comb begin
      j26       = pc4;
      j26[27:0] = {imm26_i, 2'b00};
   end

   // decode op into taken flag and the matching target form
   always_comb begin
      taken_o  = 1'b0;
      target_o = b16;
      case (br_op_i)
         BR_OP_BEQ:  taken_o = eq;
         BR_OP_J: begin
            taken_o  = 1'b1;
            target_o = j26;
         end
         BR_OP_JR: begin
            taken_o  = 1'b1;
            target_o = rs_i;
         end
         BR_OP_BNE:  taken_o = ~eq;
         BR_OP_BGEZ: taken_o = ~rs_neg;
         BR_OP_BGTZ: taken_o = ~rs_neg & ~rs_zero;
         BR_OP_BLEZ: taken_o = rs_neg | rs_zero;
         BR_OP_BLTZ: taken_o = rs_neg;
         default:    taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_gen.sv
// Registered fetch-address generator with delay-slot aware redirect buffering.
// Optional PC_ALIGN_CHECK_EN adds adel_if and blocks fetch of a misaligned pc.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
   parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEF_EXC_VECTOR)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   output logic              if_req_valid,
   input  logic              if_req_ready,
   output logic [ADDR_W-1:0] pc,
   input  logic              br_valid,
   input  logic [3:0]        br_op,
   input  logic [ADDR_W-1:0] br_pc,
   input  logic [25:0]       imm26,
   input  logic [ADDR_W-1:0] rs_reg,
   input  logic [ADDR_W-1:0] rt_reg,
   input  logic              int_req,
   input  logic              eret,
   input  logic [ADDR_W-1:0] epc,
   output logic [ADDR_W-1:0] link_pc8,
   output logic              kill_fetched
`ifdef PC_ALIGN_CHECK_EN
   ,
   output logic              adel_if
`endif
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] tgt_q, tgt_d;
   logic [0:0]        st_q, st_d;
   logic              kill_q, kill_d;
   logic              taken_raw;
   logic [ADDR_W-1:0] target;
   logic              taken;
   logic              accept;
   logic              mis;
   logic              at_ds;
   logic              past_ds;

   pc_target_calc #(
      .ADDR_W (ADDR_W)
   ) u_calc (
      .br_op_i  (br_op),
      .br_pc_i  (br_pc),
      .imm26_i  (imm26),
      .rs_i     (rs_reg),
      .rt_i     (rt_reg),
      .taken_o  (taken_raw),
      .target_o (target)
   );

`ifdef PC_ALIGN_CHECK_EN
   assign mis     = |pc_q[1:0];
   assign adel_if = mis;
`else
   assign mis     = 1'b0;
`endif

   assign taken        = br_valid & taken_raw;
   assign if_req_valid = ~stall & ~rst & ~mis;
   assign accept       = if_req_valid & if_req_ready;
   assign at_ds        = (pc_q == br_pc + ADDR_W'(4));
   assign past_ds      = (pc_q == br_pc + ADDR_W'(8));
   assign pc           = pc_q;
   assign link_pc8     = br_pc + ADDR_W'(8);
   assign kill_fetched = kill_q;

   // next pc: exceptions first, then pending redirect, then branch, then sequential
   always_comb begin
      pc_d   = pc_q;
      tgt_d  = tgt_q;
      st_d   = st_q;
      kill_d = 1'b0;
      if (int_req) begin
         pc_d = EXC_VECTOR;
         st_d = ST_SEQ;
      end else if (eret) begin
         pc_d = epc;
         st_d = ST_SEQ;
      end else if (mis) begin
         pc_d = pc_q;
      end else if (st_q == ST_WAIT_DS) begin
         if (accept) begin
            pc_d = tgt_q;
            st_d = ST_SEQ;
         end
      end else if (taken && at_ds) begin
         if (accept) begin
            pc_d = target;
         end else begin
            tgt_d = target;
            st_d  = ST_WAIT_DS;
         end
      end else if (taken && past_ds) begin
         pc_d   = target;
         kill_d = accept;
      end else if (accept) begin
         pc_d = pc_q + ADDR_W'(4);
      end
   end

   // state registers; reset drops any pending redirect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         tgt_q  <= '0;
         st_q   <= ST_SEQ;
         kill_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         tgt_q  <= tgt_d;
         st_q   <= st_d;
         kill_q <= kill_d;
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared every cycle against a behavioural fetch model.
module tb_pc_gen;
   import pc_gen_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        if_req_ready = 1'b0;
   logic        br_valid = 1'b0;
   logic [3:0]  br_op = 4'd0;
   logic [31:0] br_pc = '0;
   logic [25:0] imm26 = '0;
   logic [31:0] rs_reg = '0;
   logic [31:0] rt_reg = '0;
   logic        int_req = 1'b0;
   logic        eret = 1'b0;
   logic [31:0] epc = '0;
   logic        if_req_valid;
   logic [31:0] pc;
   logic [31:0] link_pc8;
   logic        kill_fetched;
`ifdef PC_ALIGN_CHECK_EN
   logic        adel_if;
`endif

   int checks = 0;
   int failures = 0;
   bit go = 1'b0;

   logic [31:0] m_pc;
   bit          m_pend;
   logic [31:0] m_tgt;
   bit          m_kill;

   pc_gen dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .if_req_valid (if_req_valid),
      .if_req_ready (if_req_ready),
      .pc           (pc),
      .br_valid     (br_valid),
      .br_op        (br_op),
      .br_pc        (br_pc),
      .imm26        (imm26),
      .rs_reg       (rs_reg),
      .rt_reg       (rt_reg),
      .int_req      (int_req),
      .eret         (eret),
      .epc          (epc),
      .link_pc8     (link_pc8),
      .kill_fetched (kill_fetched)
`ifdef PC_ALIGN_CHECK_EN
      ,
      .adel_if      (adel_if)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp,
                  $time);
      end
   endtask

   function automatic bit mis(input logic [31:0] a);
`ifdef PC_ALIGN_CHECK_EN
      return a[1:0] != 2'b00;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit exp_valid();
      return !stall && !rst && !mis(m_pc);
   endfunction

   function automatic bit ref_taken();
      int s;
      s = rs_reg;
      case (br_op)
         4'd1: return rs_reg == rt_reg;
         4'd2: return 1'b1;
         4'd3: return 1'b1;
         4'd4: return rs_reg != rt_reg;
         4'd5: return s >= 0;
         4'd6: return s > 0;
         4'd7: return s <= 0;
         4'd8: return s < 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] ref_target();
      logic [31:0] j;
      int off;
      if (br_op == 4'd2) begin
         j = ((br_pc + 32'd4) & 32'hF000_0000) | ({6'b0, imm26} << 2);
         return j;
      end
      if (br_op == 4'd3) return rs_reg;
      off = $signed(imm26[15:0]);
      off = off * 4;
      return br_pc + 32'd4 + off;
   endfunction

   task automatic model_reset();
      m_pc   = 32'hBFC0_0000;
      m_pend = 1'b0;
      m_tgt  = '0;
      m_kill = 1'b0;
   endtask

   // advance the model by one clock using the inputs currently applied
   task automatic model_step();
      bit acc;
      bit tk;
      logic [31:0] t;
      acc = exp_valid() && if_req_ready;
      if (rst) begin
         model_reset();
         return;
      end
      m_kill = 1'b0;
      if (int_req) begin
         m_pc = 32'hBFC0_0380;
         m_pend = 1'b0;
      end else if (eret) begin
         m_pc = epc;
         m_pend = 1'b0;
      end else if (mis(m_pc)) begin
         m_pc = m_pc;
      end else if (m_pend) begin
         if (acc) begin
            m_pc = m_tgt;
            m_pend = 1'b0;
         end
      end else begin
         tk = br_valid && ref_taken();
         t  = ref_target();
         if (tk && m_pc == br_pc + 32'd4) begin
            if (acc) m_pc = t;
            else begin
               m_pend = 1'b1;
               m_tgt  = t;
            end
         end else if (tk && m_pc == br_pc + 32'd8) begin
            m_kill = acc;
            m_pc   = t;
         end else if (acc) begin
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (go) begin
         chk("pc", pc, m_pc);
         chk("valid", {31'b0, if_req_valid}, {31'b0, exp_valid()});
         chk("kill", {31'b0, kill_fetched}, {31'b0, m_kill});
         chk("link", link_pc8, br_pc + 32'd8);
`ifdef PC_ALIGN_CHECK_EN
         chk("adel", {31'b0, adel_if}, {31'b0, mis(m_pc)});
`endif
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      br_valid = 1'b0;
      int_req  = 1'b0;
      eret     = 1'b0;
      stall    = 1'b0;
   endtask

   task automatic goto(input logic [31:0] a);
      eret = 1'b1;
      epc  = a;
      tick();
      eret = 1'b0;
      chk("goto_pc", pc, a);
   endtask

   task automatic branch(input logic [3:0] op, input logic [31:0] bpc,
                         input logic [15:0] off, input logic [31:0] rs,
                         input logic [31:0] rt);
      br_valid = 1'b1;
      br_op    = op;
      br_pc    = bpc;
      imm26    = {10'b0, off};
      rs_reg   = rs;
      rt_reg   = rt;
   endtask

   logic [31:0] vals [6];

   initial begin
      model_reset();
      rst = 1'b1;
      if_req_ready = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b1;
      tick();
      chk("rst_valid", {31'b0, if_req_valid}, 32'd0);
      chk("rst_pc", pc, 32'hBFC0_0000);
      rst = 1'b0;
      #1;
      chk("rel_valid", {31'b0, if_req_valid}, 32'd1);
      tick();
      chk("seq1", pc, 32'hBFC0_0004);
      tick();
      chk("seq2", pc, 32'hBFC0_0008);

      // beq taken while the delay slot is back-pressured
      goto(32'h104);
      if_req_ready = 1'b0;
      branch(4'd1, 32'h100, 16'h0010, 32'd5, 32'd5);
      tick();
      br_valid = 1'b0;
      tick();
      tick();
      chk("beq_hold", pc, 32'h104);
      if_req_ready = 1'b1;
      tick();
      chk("beq_tgt", pc, 32'h144);
      chk("beq_nokill", {31'b0, kill_fetched}, 32'd0);

      // bne not taken
      goto(32'h208);
      branch(4'd4, 32'h200, 16'h0010, 32'd7, 32'd7);
      tick();
      br_valid = 1'b0;
      chk("bne_seq", pc, 32'h20C);
      chk("bne_nokill", {31'b0, kill_fetched}, 32'd0);

      // jr after delay slot fetched: kill pulse
      goto(32'h308);
      branch(4'd3, 32'h300, 16'h0, 32'h8000_0040, 32'd0);
      #1;
      chk("jr_link", link_pc8, 32'h308);
      tick();
      br_valid = 1'b0;
      chk("jr_tgt", pc, 32'h8000_0040);
      chk("jr_kill", {31'b0, kill_fetched}, 32'd1);
      tick();
      chk("jr_kill_end", {31'b0, kill_fetched}, 32'd0);

      // interrupt beats eret while pending and stalled
      goto(32'h104);
      if_req_ready = 1'b0;
      branch(4'd1, 32'h100, 16'h0010, 32'd5, 32'd5);
      tick();
      br_valid = 1'b0;
      stall = 1'b1;
      int_req = 1'b1;
      eret = 1'b1;
      epc = 32'h400;
      tick();
      quiet();
      chk("int_pc", pc, 32'hBFC0_0380);
      if_req_ready = 1'b1;
      tick();
      chk("int_seq", pc, 32'hBFC0_0384);

      // bgtz / blez around zero and most-negative
      for (int k = 0; k < 4; k++) begin
         goto(32'h504);
         branch((k < 2) ? 4'd6 : 4'd7, 32'h500, 16'h0010,
                (k % 2 == 0) ? 32'd0 : 32'h8000_0000, 32'd0);
         tick();
         br_valid = 1'b0;
         chk("bgtz_blez", pc, (k < 2) ? 32'h508 : 32'h544);
      end

      // reset while a redirect is pending
      goto(32'h104);
      if_req_ready = 1'b0;
      branch(4'd1, 32'h100, 16'h0010, 32'd5, 32'd5);
      tick();
      br_valid = 1'b0;
      rst = 1'b1;
      model_reset();
      #1;
      chk("mid_rst_pc", pc, 32'hBFC0_0000);
      chk("mid_rst_valid", {31'b0, if_req_valid}, 32'd0);
      tick();
      rst = 1'b0;
      if_req_ready = 1'b1;
      tick();
      chk("rst_drop_pend", pc, 32'hBFC0_0004);

      // wrap-around
      goto(32'hFFFF_FFFC);
      tick();
      chk("wrap", pc, 32'h0);

`ifdef PC_ALIGN_CHECK_EN
      goto(32'h308);
      branch(4'd3, 32'h300, 16'h0, 32'h102, 32'd0);
      tick();
      br_valid = 1'b0;
      chk("adel_pc", pc, 32'h102);
      chk("adel_flag", {31'b0, adel_if}, 32'd1);
      chk("adel_valid", {31'b0, if_req_valid}, 32'd0);
      tick();
      chk("adel_hold", pc, 32'h102);
      goto(32'h0);
`endif

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom % 150) == 0;
         if (rst) model_reset();
         stall        = ($urandom % 5) == 0;
         if_req_ready = ($urandom % 3) != 0;
         int_req      = ($urandom % 40) == 0;
         eret         = ($urandom % 40) == 0;
         epc          = $urandom;
         if (($urandom % 4) != 0) epc[1:0] = 2'b00;
         vals[0] = 32'd0;
         vals[1] = 32'd5;
         vals[2] = 32'h8000_0000;
         vals[3] = 32'hFFFF_FFFF;
         vals[4] = 32'd1;
         vals[5] = $urandom & 32'hFFFF_FFFC;
         br_valid = ($urandom % 2) == 0;
         br_op    = 4'($urandom % 10);
         br_pc    = m_pc - ((($urandom % 2) == 0) ? 32'd4 : 32'd8);
         if (($urandom % 8) == 0) br_pc = $urandom;
         imm26    = 26'($urandom);
         rs_reg   = vals[$urandom % 6];
         rt_reg   = vals[$urandom % 6];
         tick();
      end
      rst = 1'b0;
      quiet();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
